vga_timing_core: RTL and testbench
==================================

// Module: vga_timing_core
// PURPOSE
//  Parametrised single-clock VGA raster timing generator. Replaces the ripple-clocked
//  (HS-clocked vertical) scheme: both counters run on clk, advanced by a pixel-enable
//  strobe. Timing, sync polarity and counter width are set by parameters.
//  Feeds the pixel pipeline (x/y/active) and the VGA pad drivers (hs/vs).
// PARAMETERS
//  CNT_W     10   counter / coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   horizontal sync width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      33   vertical back porch (lines)
//  HS_POL    0    hs level during sync pulse (0 = active-low)
//  VS_POL    0    vs level during sync pulse (0 = active-low)
// PORTS
//  clk          in   1      system clock; the only clock
//  rst          in   1      reset, synchronous, active-high
//  pix_en       in   1      pixel strobe; counters advance only on clk edges where high
//  x            out  CNT_W  horizontal count; 0..H_ACTIVE-1 is visible
//  y            out  CNT_W  vertical count; 0..V_ACTIVE-1 is visible
//  active       out  1      high while x<H_ACTIVE and y<V_ACTIVE
//  hs           out  1      horizontal sync, level set by HS_POL
//  vs           out  1      vertical sync, level set by VS_POL
//  line_start   out  1      one-pix_en-period pulse at x==0
//  frame_start  out  1      one-pix_en-period pulse at x==0, y==0
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Line order: active, front porch, sync, back porch. H_TOTAL = sum of the four H params;
//    V_TOTAL is defined the same way from the V params.
//  - hsync region: H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC. vsync region: same form in y.
//  - Reset: h_cnt <= H_TOTAL-1 and v_cnt <= V_TOTAL-1 (last raster position).
//    Outputs during reset:
//      - active, line_start and frame_start are 0.
//      - hs = ~HS_POL and vs = ~VS_POL.
//      - x = H_TOTAL-1 and y = V_TOTAL-1.
//  - First pix_en after reset moves the raster to (0,0). On that edge active,
//    line_start and frame_start all go to 1.
//  - On a clk edge with pix_en=1:
//      - h_cnt wraps from H_TOTAL-1 to 0 and otherwise increments.
//      - v_cnt changes only when h_cnt wraps: V_TOTAL-1 goes to 0, otherwise it increments.
//  - pix_en=0: every register holds, including the start pulses. Pulses therefore last
//    from one pix_en edge to the next.
//  - All outputs are registered and decoded from the next-state counters. They change on
//    the same clk edge as the counters, so x, y, active, hs, vs and the pulses have
//    zero relative skew.
//  - vs switches on the line-wrap edge (x becomes 0), never mid-line.
//  - rst has priority over pix_en when both are high. Mid-frame reset returns to the
//    reset state on the next edge.
//  - Widths: compares use CNT_W-bit unsigned values. Elaboration-time check: error if
//    H_TOTAL or V_TOTAL exceeds 2**CNT_W, or if any timing parameter is 0.
// STRUCTURE
//  - Package vga_timing_pkg holds:
//      - the default 640x480@60 constants (H_*, V_*),
//      - helper functions for total and sync-start computation,
//      - the sync polarity localparams.
//  - One sub-module, vga_axis_counter (params CNT_W, ACTIVE, FP, SYNC, BP, POL):
//      - ports: clk, rst, en, cnt, wrap, in_active, sync.
//      - instantiated twice. Horizontal en = pix_en; vertical en = pix_en & h wrap.
//  - The top level combines the two axes into active, line_start and frame_start,
//    and registers them.
// TESTING
//  Use small params H=8/2/3/2 and V=4/1/2/1, giving H_TOTAL=15 and V_TOTAL=8.
//  - Reset, then pix_en held high:
//      - during reset: x=14, y=7, hs=vs=1 with POL=0.
//      - first edge gives x=0, y=0, active=1, frame_start=1.
//  - Continuous pix_en for one line:
//      - active is 1 for exactly 8 edges.
//      - hs=0 while x is 10..12.
//      - line_start is high only at x=0.
//  - Full frame: vs low while y is 5..6 (2 lines).
//    frame_start is seen once every 120 enabled edges.
//  - pix_en=1 every 4th clk: every output holds for 3 clks between strobes.
//    Frame period is 480 clks.
//  - Assert rst at x=5, y=2:
//      - next edge gives the reset state.
//      - rst together with pix_en keeps the reset state.
//  - HS_POL=1, VS_POL=1: sync levels invert relative to the POL=0 run.
//    Every other output is bit-identical.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
package vga_timing_pkg;

   // Default 640x480@60 horizontal timing (pixels)
   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;

   // Default 640x480@60 vertical timing (lines)
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   // Sync levels during the pulse (0 = active-low)
   localparam logic HS_POL_DEF = 1'b0;
   localparam logic VS_POL_DEF = 1'b0;

   // Total positions on one axis
   function automatic int unsigned axis_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   // First count inside the sync pulse
   function automatic int unsigned sync_start(input int unsigned active,
                                              input int unsigned fp);
      return active + fp;
   endfunction

endpackage

// File: rtl/vga_timing_core_if.sv
// Pixel-strobe input and raster outputs of the timing core.
interface vga_timing_core_if #(
   parameter int unsigned CNT_W = 10
);
   logic             pix_en;
   logic [CNT_W-1:0] x;
   logic [CNT_W-1:0] y;
   logic             active;
   logic             hs;
   logic             vs;
   logic             line_start;
   logic             frame_start;

   modport master (
      input  pix_en,
      output x, y, active, hs, vs, line_start, frame_start
   );

   modport slave (
      output pix_en,
      input  x, y, active, hs, vs, line_start, frame_start
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus registered sync decode.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned CNT_W  = 10,
   parameter int unsigned ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned FP     = H_FP_DEF,
   parameter int unsigned SYNC   = H_SYNC_DEF,
   parameter int unsigned BP     = H_BP_DEF,
   parameter logic        POL    = HS_POL_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap,
   output logic             in_active,
   output logic             sync
);

   localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
   localparam int unsigned SYNC_B = sync_start(ACTIVE, FP);
   localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] ACT_C    = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_S_C = CNT_W'(SYNC_B);
   localparam logic [CNT_W-1:0] SYNC_E_C = CNT_W'(SYNC_B + SYNC);

   logic [CNT_W-1:0] r_cnt;
   logic             r_sync;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_after;

   // Next count and the count this edge will leave behind
   assign wrap        = (r_cnt == LAST_C);
   assign w_cnt_nxt   = wrap ? '0 : r_cnt + CNT_W'(1);
   assign w_cnt_after = en ? w_cnt_nxt : r_cnt;
   // Lookahead: position after this edge lies in the visible region
   assign in_active   = (w_cnt_after < ACT_C);

   // Counter and sync register, both decoded from the next count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= LAST_C;
         r_sync <= ~POL;
      end else if (en) begin
         r_cnt  <= w_cnt_nxt;
         r_sync <= ((w_cnt_nxt >= SYNC_S_C) && (w_cnt_nxt < SYNC_E_C)) ? POL : ~POL;
      end
   end

   assign cnt  = r_cnt;
   assign sync = r_sync;

endmodule

// File: rtl/vga_timing_core.sv
// Single-clock VGA raster timing generator built from two axis counters.
module vga_timing_core
   import vga_timing_pkg::*;
#(
   parameter int unsigned CNT_W    = 10,
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter logic        HS_POL   = HS_POL_DEF,
   parameter logic        VS_POL   = VS_POL_DEF
) (
   input  logic               clk,
   input  logic               rst,
   vga_timing_core_if.master  bus
);

   localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam longint unsigned CNT_RANGE = 64'(1) << CNT_W;

   // Reject timings that do not fit the counters or have an empty region
   if ((64'(H_TOTAL) > CNT_RANGE) || (64'(V_TOTAL) > CNT_RANGE)) begin : g_bad_width
      $error("vga_timing_core: H_TOTAL or V_TOTAL exceeds 2**CNT_W");
   end
   if ((H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
       (V_ACTIVE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_bad_zero
      $error("vga_timing_core: timing parameters must be non-zero");
   end

   logic [CNT_W-1:0] w_h_cnt;
   logic [CNT_W-1:0] w_v_cnt;
   logic             w_h_wrap;
   logic             w_v_wrap;
   logic             w_h_in_active;
   logic             w_v_in_active;
   logic             w_h_sync;
   logic             w_v_sync;
   logic             w_v_en;
   logic             r_active;
   logic             r_line_start;
   logic             r_frame_start;

   // Vertical axis steps only on the horizontal wrap edge
   assign w_v_en = bus.pix_en & w_h_wrap;

   vga_axis_counter #(
      .CNT_W (CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP),
      .SYNC  (H_SYNC), .BP(H_BP), .POL(HS_POL)
   ) u_h_axis (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.pix_en),
      .cnt       (w_h_cnt),
      .wrap      (w_h_wrap),
      .in_active (w_h_in_active),
      .sync      (w_h_sync)
   );

   vga_axis_counter #(
      .CNT_W (CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP),
      .SYNC  (V_SYNC), .BP(V_BP), .POL(VS_POL)
   ) u_v_axis (
      .clk       (clk),
      .rst       (rst),
      .en        (w_v_en),
      .cnt       (w_v_cnt),
      .wrap      (w_v_wrap),
      .in_active (w_v_in_active),
      .sync      (w_v_sync)
   );

   // Raster flags registered on the same edge as the counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_active      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (bus.pix_en) begin
         r_active      <= w_h_in_active & w_v_in_active;
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_h_wrap & w_v_wrap;
      end
   end

   assign bus.x           = w_h_cnt;
   assign bus.y           = w_v_cnt;
   assign bus.hs          = w_h_sync;
   assign bus.vs          = w_v_sync;
   assign bus.active      = r_active;
   assign bus.line_start  = r_line_start;
   assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_core.sv
// Self-checking bench: small raster, both sync polarities, scoreboard of expected outputs.
module tb_vga_timing_core;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
      logic       active;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pix_en = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   mx = 14;
   int   my = 7;
   obs_t a0, a1, e0, e1;
   obs_t q0[$];
   obs_t q1[$];

   always #5 clk = ~clk;

   vga_timing_core_if #(.CNT_W(4)) bus0 ();
   vga_timing_core_if #(.CNT_W(4)) bus1 ();
   assign bus0.pix_en = pix_en;
   assign bus1.pix_en = pix_en;

   vga_timing_core #(
      .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

   vga_timing_core #(
      .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Expected outputs at raster position (px,py)
   function automatic obs_t exp_of(input int px, input int py, input logic pol);
      obs_t e;
      e.x      = 4'(px);
      e.y      = 4'(py);
      e.active = (px < 8) && (py < 4);
      e.hs     = (px >= 10 && px < 13) ? pol : ~pol;
      e.vs     = (py >= 5 && py < 7) ? pol : ~pol;
      e.ls     = (px == 0);
      e.fs     = (px == 0) && (py == 0);
      return e;
   endfunction

   // Drive one clk, advance the reference raster, push expectations, sample
   task automatic step(input logic pe, input logic rs);
      pix_en = pe;
      rst    = rs;
      if (rs) begin
         mx = 14; my = 7;
      end else if (pe) begin
         if (mx == 14) begin
            mx = 0;
            my = (my == 7) ? 0 : my + 1;
         end else begin
            mx = mx + 1;
         end
      end
      q0.push_back(exp_of(mx, my, 1'b0));
      q1.push_back(exp_of(mx, my, 1'b1));
      @(posedge clk);
      #1;
      a0 = {bus0.x, bus0.y, bus0.active, bus0.hs, bus0.vs, bus0.line_start, bus0.frame_start};
      a1 = {bus1.x, bus1.y, bus1.active, bus1.hs, bus1.vs, bus1.line_start, bus1.frame_start};
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1);
         e0 = q0.pop_front(); e1 = q1.pop_front(); n_tests++;
         if (a0 !== e0 || a1 !== e1) begin
            n_fail++;
            $display("FAIL reset[%0d] pol0 got %h exp %h pol1 got %h exp %h", i, a0, e0, a1, e1);
         end
      end
   endtask

   task automatic test_first_edge();
      step(1'b1, 1'b0);
      e0 = q0.pop_front(); e1 = q1.pop_front(); n_tests++;
      if (a0 !== e0 || a1 !== e1) begin
         n_fail++;
         $display("FAIL first_edge pol0 got %h exp %h pol1 got %h exp %h", a0, e0, a1, e1);
      end
   endtask

   task automatic test_line();
      int act_cnt = int'(a0.active);
      int ls_cnt  = int'(a0.ls);
      int hs_lo   = int'(!a0.hs);
      for (int i = 1; i < 15; i++) begin
         step(1'b1, 1'b0);
         e0 = q0.pop_front(); e1 = q1.pop_front(); n_tests++;
         if (a0 !== e0 || a1 !== e1) begin
            n_fail++;
            $display("FAIL line[x=%0d] pol0 got %h exp %h pol1 got %h exp %h", i, a0, e0, a1, e1);
         end
         act_cnt += int'(a0.active);
         ls_cnt  += int'(a0.ls);
         hs_lo   += int'(!a0.hs);
      end
      n_tests++;
      if (act_cnt !== 8) begin n_fail++; $display("FAIL line_active_count got %0d exp 8", act_cnt); end
      n_tests++;
      if (ls_cnt !== 1) begin n_fail++; $display("FAIL line_start_count got %0d exp 1", ls_cnt); end
      n_tests++;
      if (hs_lo !== 3) begin n_fail++; $display("FAIL hs_low_count got %0d exp 3", hs_lo); end
   endtask

   task automatic test_frame();
      int fs_cnt = 0;
      int vs_lo  = 0;
      for (int i = 0; i < 120; i++) begin
         step(1'b1, 1'b0);
         e0 = q0.pop_front(); e1 = q1.pop_front(); n_tests++;
         if (a0 !== e0 || a1 !== e1) begin
            n_fail++;
            $display("FAIL frame[%0d] pol0 got %h exp %h pol1 got %h exp %h", i, a0, e0, a1, e1);
         end
         fs_cnt += int'(a0.fs);
         vs_lo  += int'(!a0.vs);
      end
      n_tests++;
      if (fs_cnt !== 1) begin n_fail++; $display("FAIL frame_start_count got %0d exp 1", fs_cnt); end
      n_tests++;
      if (vs_lo !== 30) begin n_fail++; $display("FAIL vs_low_edges got %0d exp 30", vs_lo); end
   endtask

   task automatic test_strobe();
      logic prev_fs = a0.fs;
      int   rise0 = -1;
      int   rise1 = -1;
      for (int i = 0; i < 960; i++) begin
         step((i % 4) == 0, 1'b0);
         e0 = q0.pop_front(); e1 = q1.pop_front(); n_tests++;
         if (a0 !== e0 || a1 !== e1) begin
            n_fail++;
            $display("FAIL strobe[clk %0d] pol0 got %h exp %h pol1 got %h exp %h", i, a0, e0, a1, e1);
         end
         if (a0.fs && !prev_fs) begin
            if (rise0 < 0) rise0 = i;
            else if (rise1 < 0) rise1 = i;
         end
         prev_fs = a0.fs;
      end
      n_tests++;
      if (rise0 < 0 || rise1 < 0 || (rise1 - rise0) !== 480) begin
         n_fail++;
         $display("FAIL frame_period rises %0d,%0d gap got %0d exp 480", rise0, rise1, rise1 - rise0);
      end
   endtask

   task automatic test_mid_reset();
      int guard = 0;
      while (!(mx == 5 && my == 2) && guard < 200) begin
         step(1'b1, 1'b0);
         e0 = q0.pop_front(); e1 = q1.pop_front(); n_tests++;
         if (a0 !== e0 || a1 !== e1) begin
            n_fail++;
            $display("FAIL seek pol0 got %h exp %h pol1 got %h exp %h", a0, e0, a1, e1);
         end
         guard++;
      end
      n_tests++;
      if (guard >= 200) begin n_fail++; $display("FAIL seek_timeout got %0d,%0d exp 5,2", mx, my); end
      for (int i = 0; i < 4; i++) begin
         // rst alone, rst with pix_en twice, then release with pix_en
         step((i != 0), (i != 3));
         e0 = q0.pop_front(); e1 = q1.pop_front(); n_tests++;
         if (a0 !== e0 || a1 !== e1) begin
            n_fail++;
            $display("FAIL mid_reset[%0d] pol0 got %h exp %h pol1 got %h exp %h", i, a0, e0, a1, e1);
         end
      end
   endtask

   task automatic test_pol_identity();
      obs_t m0 = a0;
      obs_t m1 = a1;
      n_tests++;
      if ({m0.x, m0.y, m0.active, m0.ls, m0.fs} !== {m1.x, m1.y, m1.active, m1.ls, m1.fs} ||
          m0.hs !== ~m1.hs || m0.vs !== ~m1.vs) begin
         n_fail++;
         $display("FAIL pol_identity pol0 %h pol1 %h exp only hs/vs inverted", m0, m1);
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_first_edge();
      test_line();
      test_frame();
      test_strobe();
      test_pol_identity();
      test_mid_reset();
      test_pol_identity();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
